// File: rtl/dnc_write_heads_unit.sv
// dnc_write_heads_unit: multi-head DNC write-head interface processor.
// Per transfer it latches one head's gates/strength (hard-sigmoid / oneplus)
// and then streams W key/erase/write-vector elements with 1-cycle latency.
// Optional macro DNC_WRITE_HEADS_STATUS_EN adds a sticky ERROR output.
module dnc_write_heads_unit #(
    parameter int DATA_SIZE = 32,
    parameter int FRAC_BITS = 16,
    parameter int HEADS     = 4,
    parameter int HEAD_SIZE = (HEADS > 1) ? $clog2(HEADS) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic [HEAD_SIZE-1:0] HEAD_IN,
    input  logic [DATA_SIZE-1:0] SIZE_W_IN,
    input  logic [DATA_SIZE-1:0] BETA_IN,
    input  logic [DATA_SIZE-1:0] GA_IN,
    input  logic [DATA_SIZE-1:0] GW_IN,
    input  logic                 VEC_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] K_IN,
    input  logic [DATA_SIZE-1:0] E_IN,
    input  logic [DATA_SIZE-1:0] V_IN,
    output logic                 VEC_OUT_ENABLE,
    output logic [DATA_SIZE-1:0] K_OUT,
    output logic [DATA_SIZE-1:0] E_OUT,
    output logic [DATA_SIZE-1:0] V_OUT,
    output logic [DATA_SIZE-1:0] BETA_OUT,
    output logic [DATA_SIZE-1:0] GA_OUT,
    output logic [DATA_SIZE-1:0] GW_OUT,
    output logic [HEAD_SIZE-1:0] HEAD_OUT,
    output logic [HEADS-1:0]     WRITTEN_OUT,
`ifdef DNC_WRITE_HEADS_STATUS_EN
    input  logic                 CLEAR,
    output logic                 ERROR
`else
    input  logic                 CLEAR
`endif
);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    // One extra bit of headroom so activation intermediates never wrap.
    localparam logic signed [DATA_SIZE:0] ONE_X  =
        {{(DATA_SIZE-FRAC_BITS){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};
    localparam logic signed [DATA_SIZE:0] HALF_X = ONE_X >>> 1;
    localparam logic signed [DATA_SIZE:0] MAX_X  = {2'b00, {(DATA_SIZE-1){1'b1}}};
    localparam logic [HEAD_SIZE:0]        HEADS_L = (HEAD_SIZE+1)'(HEADS);

    function automatic logic signed [DATA_SIZE:0] hs_raw(input logic [DATA_SIZE-1:0] x);
        return ($signed({x[DATA_SIZE-1], x}) >>> 2) + HALF_X;
    endfunction

    function automatic logic [DATA_SIZE-1:0] hs_clip(input logic signed [DATA_SIZE:0] r);
        if (r[DATA_SIZE])  return '0;
        if (r > ONE_X)     return ONE_X[DATA_SIZE-1:0];
        return r[DATA_SIZE-1:0];
    endfunction

    // Negative strength contributes nothing, so oneplus bottoms out at ONE.
    function automatic logic signed [DATA_SIZE:0] op_raw(input logic [DATA_SIZE-1:0] x);
        if (x[DATA_SIZE-1]) return ONE_X;
        return ONE_X + $signed({1'b0, x});
    endfunction

    function automatic logic [DATA_SIZE-1:0] op_clip(input logic signed [DATA_SIZE:0] r);
        if (r > MAX_X) return MAX_X[DATA_SIZE-1:0];
        return r[DATA_SIZE-1:0];
    endfunction

    logic signed [DATA_SIZE:0] beta_raw, ga_raw, gw_raw, e_raw;
    assign beta_raw = op_raw(BETA_IN);
    assign ga_raw   = hs_raw(GA_IN);
    assign gw_raw   = hs_raw(GW_IN);
    assign e_raw    = hs_raw(E_IN);

    state_t                 state_q, state_d;
    logic [HEAD_SIZE-1:0]   head_q, head_d;
    logic [DATA_SIZE-1:0]   w_q, w_d, cnt_q, cnt_d;
    logic [DATA_SIZE-1:0]   beta_q, beta_d, ga_q, ga_d, gw_q, gw_d;
    logic [DATA_SIZE-1:0]   k_q, k_d, e_q, e_d, v_q, v_d;
    logic                   vld_q, vld_d, ready_q, ready_d;
    logic [HEADS-1:0]       written_q, written_d;
    logic                   head_ok;

    assign head_ok = ({1'b0, HEAD_IN} < HEADS_L);

`ifdef DNC_WRITE_HEADS_STATUS_EN
    logic err_q, err_d, err_set;

    // Sticky status: any protocol misuse or activation clamp raises ERROR.
    always_comb begin
        err_set = 1'b0;
        if (START && (state_q != IDLE || !head_ok))
            err_set = 1'b1;
        if (VEC_IN_ENABLE && state_q != STREAM)
            err_set = 1'b1;
        if (state_q == IDLE && START && head_ok &&
            (beta_raw > MAX_X ||
             ga_raw[DATA_SIZE] || ga_raw > ONE_X ||
             gw_raw[DATA_SIZE] || gw_raw > ONE_X))
            err_set = 1'b1;
        if (state_q == STREAM && VEC_IN_ENABLE && (e_raw[DATA_SIZE] || e_raw > ONE_X))
            err_set = 1'b1;
        err_d = (CLEAR ? 1'b0 : err_q) | err_set;
    end

    assign ERROR = err_q;
`endif

    // Next-state and output-register computation for the transfer FSM.
    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        w_d       = w_q;
        cnt_d     = cnt_q;
        beta_d    = beta_q;
        ga_d      = ga_q;
        gw_d      = gw_q;
        k_d       = k_q;
        e_d       = e_q;
        v_d       = v_q;
        vld_d     = 1'b0;
        ready_d   = 1'b0;
        written_d = CLEAR ? '0 : written_q;
        case (state_q)
            IDLE: begin
                if (START && head_ok) begin
                    head_d  = HEAD_IN;
                    w_d     = SIZE_W_IN;
                    cnt_d   = '0;
                    beta_d  = op_clip(beta_raw);
                    ga_d    = hs_clip(ga_raw);
                    gw_d    = hs_clip(gw_raw);
                    state_d = (SIZE_W_IN == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (VEC_IN_ENABLE) begin
                    vld_d = 1'b1;
                    k_d   = K_IN;
                    e_d   = hs_clip(e_raw);
                    v_d   = V_IN;
                    cnt_d = cnt_q + DATA_SIZE'(1);
                    if (cnt_q + DATA_SIZE'(1) == w_q)
                        state_d = DONE;
                end
            end
            DONE: begin
                ready_d = 1'b1;
                state_d = IDLE;
                // A completion set overrides a coincident CLEAR for this head.
                for (int h = 0; h < HEADS; h++)
                    if (head_q == HEAD_SIZE'(h))
                        written_d[h] = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            head_q    <= '0;
            w_q       <= '0;
            cnt_q     <= '0;
            beta_q    <= '0;
            ga_q      <= '0;
            gw_q      <= '0;
            k_q       <= '0;
            e_q       <= '0;
            v_q       <= '0;
            vld_q     <= 1'b0;
            ready_q   <= 1'b0;
            written_q <= '0;
`ifdef DNC_WRITE_HEADS_STATUS_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            w_q       <= w_d;
            cnt_q     <= cnt_d;
            beta_q    <= beta_d;
            ga_q      <= ga_d;
            gw_q      <= gw_d;
            k_q       <= k_d;
            e_q       <= e_d;
            v_q       <= v_d;
            vld_q     <= vld_d;
            ready_q   <= ready_d;
            written_q <= written_d;
`ifdef DNC_WRITE_HEADS_STATUS_EN
            err_q     <= err_d;
`endif
        end
    end

    assign READY          = ready_q;
    assign VEC_OUT_ENABLE = vld_q;
    assign K_OUT          = k_q;
    assign E_OUT          = e_q;
    assign V_OUT          = v_q;
    assign BETA_OUT       = beta_q;
    assign GA_OUT         = ga_q;
    assign GW_OUT         = gw_q;
    assign HEAD_OUT       = head_q;
    assign WRITTEN_OUT    = written_q;

endmodule

// File: tb/tb_dnc_write_heads_unit.sv
// Bench for dnc_write_heads_unit: directed test-plan steps plus randomized
// transfers, checked against an arithmetic model of the activations.
module tb_dnc_write_heads_unit;

    logic        CLK = 1'b0;
    logic        RST, START, VEC_IN_ENABLE, CLEAR;
    logic [2:0]  HEAD_IN;
    logic [31:0] SIZE_W_IN, BETA_IN, GA_IN, GW_IN, K_IN, E_IN, V_IN;
    logic        READY, VEC_OUT_ENABLE;
    logic [31:0] K_OUT, E_OUT, V_OUT, BETA_OUT, GA_OUT, GW_OUT;
    logic [2:0]  HEAD_OUT;
    logic [3:0]  WRITTEN_OUT;
`ifdef DNC_WRITE_HEADS_STATUS_EN
    logic        ERROR;
`endif

    // HEAD_SIZE=3 so that an out-of-range head index (4) can be driven.
    dnc_write_heads_unit #(.DATA_SIZE(32), .FRAC_BITS(16), .HEADS(4), .HEAD_SIZE(3)) dut (
        .CLK(CLK), .RST(RST), .START(START), .READY(READY),
        .HEAD_IN(HEAD_IN), .SIZE_W_IN(SIZE_W_IN), .BETA_IN(BETA_IN),
        .GA_IN(GA_IN), .GW_IN(GW_IN), .VEC_IN_ENABLE(VEC_IN_ENABLE),
        .K_IN(K_IN), .E_IN(E_IN), .V_IN(V_IN), .VEC_OUT_ENABLE(VEC_OUT_ENABLE),
        .K_OUT(K_OUT), .E_OUT(E_OUT), .V_OUT(V_OUT), .BETA_OUT(BETA_OUT),
        .GA_OUT(GA_OUT), .GW_OUT(GW_OUT), .HEAD_OUT(HEAD_OUT),
        .WRITTEN_OUT(WRITTEN_OUT),
`ifdef DNC_WRITE_HEADS_STATUS_EN
        .CLEAR(CLEAR), .ERROR(ERROR)
`else
        .CLEAR(CLEAR)
`endif
    );

    always #5 CLK = ~CLK;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  exp_wr  = '0;
    logic [31:0] last_k = '0, last_e = '0, last_v = '0;
    logic [31:0] ek[64], ee[64], ev[64];
    bit          en_pat[$];

    // Reference activations from the defining formulas in wide signed math.
    function automatic logic [31:0] hs_m(input logic [31:0] x);
        longint r;
        r = longint'($signed(x));
        r = (r >>> 2) + 64'sd32768;
        if (r < 0)     r = 0;
        if (r > 65536) r = 65536;
        return r[31:0];
    endfunction

    function automatic logic [31:0] op_m(input logic [31:0] x);
        longint r;
        r = longint'($signed(x));
        if (r < 0) r = 0;
        r = r + 64'sd65536;
        if (r > 64'sd2147483647) r = 64'sd2147483647;
        return r[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One full transfer: accept, stream W elements (pattern or random gaps), DONE/READY.
    task automatic do_xfer(input int head, input int w, input logic [31:0] beta,
                           input logic [31:0] ga, input logic [31:0] gw,
                           input bit midstart, input bit clr_done);
        int sent = 0;
        int guard = 0;
        bit en;
        bit injected = 0;
        HEAD_IN = 3'(head); SIZE_W_IN = w; BETA_IN = beta; GA_IN = ga; GW_IN = gw;
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("head_acc", 32'(HEAD_OUT), head);
        chk("beta_out", BETA_OUT, op_m(beta));
        chk("ga_out", GA_OUT, hs_m(ga));
        chk("gw_out", GW_OUT, hs_m(gw));
        chk("vld_acc", 32'(VEC_OUT_ENABLE), 0);
        chk("ready_acc", 32'(READY), 0);
        while (sent < w && guard < 200) begin
            guard++;
            en = (en_pat.size() > 0) ? en_pat.pop_front() : ($urandom_range(0, 2) != 0);
            if (!en && midstart && !injected) begin
                START = 1'b1; HEAD_IN = 3'd0; SIZE_W_IN = 32'd1; BETA_IN = 32'h1234;
                injected = 1;
            end
            VEC_IN_ENABLE = en;
            K_IN = ek[sent]; E_IN = ee[sent]; V_IN = ev[sent];
            tick();
            START = 1'b0; VEC_IN_ENABLE = 1'b0;
            chk("vld_stream", 32'(VEC_OUT_ENABLE), 32'(en));
            chk("ready_stream", 32'(READY), 0);
            if (en) begin
                last_k = ek[sent]; last_e = hs_m(ee[sent]); last_v = ev[sent];
                sent++;
            end
            chk("k_out", K_OUT, last_k);
            chk("e_out", E_OUT, last_e);
            chk("v_out", V_OUT, last_v);
        end
        if (clr_done) CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        if (clr_done) exp_wr = '0;
        exp_wr[head] = 1'b1;
        chk("ready_done", 32'(READY), 1);
        chk("vld_done", 32'(VEC_OUT_ENABLE), 0);
        chk("written", 32'(WRITTEN_OUT), 32'(exp_wr));
        chk("head_hold", 32'(HEAD_OUT), head);
        tick();
        chk("ready_pulse", 32'(READY), 0);
    endtask

    task automatic fill_rand(input int w);
        logic [31:0] t;
        for (int i = 0; i < w; i++) begin
            t = $urandom();
            ek[i] = $urandom();
            ev[i] = $urandom();
            ee[i] = (i % 2 == 1) ? t : {{14{t[17]}}, t[17:0]};
        end
    endtask

    initial begin
        RST = 1'b0; START = 1'b0; VEC_IN_ENABLE = 1'b0; CLEAR = 1'b0;
        HEAD_IN = '0; SIZE_W_IN = '0; BETA_IN = '0; GA_IN = '0; GW_IN = '0;
        K_IN = '0; E_IN = '0; V_IN = '0;
        tick(); tick();
        chk("rst_ready", 32'(READY), 0);
        chk("rst_vld", 32'(VEC_OUT_ENABLE), 0);
        chk("rst_written", 32'(WRITTEN_OUT), 0);
        chk("rst_head", 32'(HEAD_OUT), 0);
        chk("rst_beta", BETA_OUT, 0);
        chk("rst_gw", GW_OUT, 0);
        chk("rst_e", E_OUT, 0);
`ifdef DNC_WRITE_HEADS_STATUS_EN
        chk("rst_error", 32'(ERROR), 0);
`endif
        RST = 1'b1;
        tick();

        // Plan step 1: head 1, W=3, back-to-back elements.
        ek[0] = 1; ek[1] = 2; ek[2] = 3;
        ee[0] = 32'h0004_0000; ee[1] = 32'hFFFE_0000; ee[2] = 32'h0;
        ev[0] = 32'hA; ev[1] = 32'hB; ev[2] = 32'hC;
        en_pat = '{1, 1, 1};
        do_xfer(1, 3, 32'h0002_8000, 32'h0, 32'h0001_0000, 0, 0);
        chk("p1_beta", BETA_OUT, 32'h0003_8000);
        chk("p1_ga", GA_OUT, 32'h0000_8000);
        chk("p1_gw", GW_OUT, 32'h0000_C000);
        chk("p1_e_last", E_OUT, 32'h0000_8000);
        chk("p1_k_last", K_OUT, 32'd3);
        chk("p1_written", 32'(WRITTEN_OUT), 32'h2);

        // Plan step 2: W=0 on head 3 with negative beta.
        do_xfer(3, 0, 32'hFFFB_0000, 32'h0, 32'h0, 0, 0);
        chk("p2_beta", BETA_OUT, 32'h0001_0000);
        chk("p2_written", 32'(WRITTEN_OUT), 32'hA);

        // Plan step 3: W=4 with input gaps and an ignored mid-stream START.
        fill_rand(4);
        en_pat = '{1, 0, 1, 0, 0, 1, 1};
        do_xfer(2, 4, $urandom(), $urandom(), $urandom(), 1, 0);

        // Elements offered while idle are dropped.
        VEC_IN_ENABLE = 1'b1; K_IN = ~last_k;
        tick();
        VEC_IN_ENABLE = 1'b0;
        chk("idle_drop_vld", 32'(VEC_OUT_ENABLE), 0);
        chk("idle_drop_k", K_OUT, last_k);

        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        exp_wr = '0;
        chk("clear_written", 32'(WRITTEN_OUT), 0);
`ifdef DNC_WRITE_HEADS_STATUS_EN
        chk("clear_error", 32'(ERROR), 0);
`endif

        // Plan step 4: out-of-range head is not accepted.
        HEAD_IN = 3'd4; SIZE_W_IN = 0; BETA_IN = 32'h7; START = 1'b1;
        tick();
        START = 1'b0;
        chk("bad_head_hold", 32'(HEAD_OUT), 2);
        for (int i = 0; i < 3; i++) begin
            chk("bad_head_ready", 32'(READY), 0);
            tick();
        end
        chk("bad_head_written", 32'(WRITTEN_OUT), 0);
`ifdef DNC_WRITE_HEADS_STATUS_EN
        chk("bad_head_error", 32'(ERROR), 1);
`endif

        // Plan step 5: CLEAR coincident with DONE of head 2 keeps only bit 2.
        do_xfer(0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        chk("p5_before", 32'(WRITTEN_OUT), 32'h1);
        fill_rand(1);
        do_xfer(2, 1, $urandom(), 32'h0, 32'h0, 0, 1);
        chk("p5_after", 32'(WRITTEN_OUT), 32'h4);

        // Plan step 6: reset after 2 of 5 elements aborts the transfer.
        fill_rand(5);
        HEAD_IN = 3'd1; SIZE_W_IN = 5; BETA_IN = 32'h100; GA_IN = 0; GW_IN = 0;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 2; i++) begin
            VEC_IN_ENABLE = 1'b1; K_IN = ek[i]; E_IN = ee[i]; V_IN = ev[i];
            tick();
        end
        VEC_IN_ENABLE = 1'b0;
        #2 RST = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(READY), 0);
        chk("mid_rst_vld", 32'(VEC_OUT_ENABLE), 0);
        chk("mid_rst_k", K_OUT, 0);
        chk("mid_rst_beta", BETA_OUT, 0);
        chk("mid_rst_head", 32'(HEAD_OUT), 0);
        chk("mid_rst_written", 32'(WRITTEN_OUT), 0);
        tick();
        RST = 1'b1;
        exp_wr = '0; last_k = '0; last_e = '0; last_v = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_ready", 32'(READY), 0);
        end
        fill_rand(3);
        do_xfer(3, 3, $urandom(), $urandom(), $urandom(), 0, 0);

        // Randomized transfers, including saturating activations.
        for (int r = 0; r < 8; r++) begin
            int w;
            w = $urandom_range(0, 6);
            fill_rand(w);
            do_xfer($urandom_range(0, 3), w, $urandom(), $urandom(), $urandom(),
                    ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
